// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction memory fetch sequencer with 2-entry output buffer
// Issues one read per cycle and hides the one-cycle memory latency behind the buffer.
module imem_fetch_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int RESET_PC   = 0,
   parameter int END_PC     = 17,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_data,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  accepted_cnt
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);
   localparam logic [ADDR_WIDTH-1:0] END_ADDR   = ADDR_WIDTH'(END_PC);

   state_t                state;
   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic [ADDR_WIDTH-1:0] inflight_pc;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] buf_data [2];
   logic [ADDR_WIDTH-1:0] buf_pc   [2];
   logic [1:0]            count;

   logic       pop;
   logic       issue;
   logic [1:0] count_after_pop;
   logic [1:0] count_next;
   logic [2:0] occupancy;

   // Occupancy counts the in-flight word as already buffered so a read is
   // only issued when a slot is guaranteed for its return.
   always_comb begin
      pop             = (count != 2'd0) && instr_ready;
      count_after_pop = count - {1'b0, pop};
      count_next      = count_after_pop + {1'b0, inflight};
      occupancy       = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
      issue           = (state == S_RUN) && (fetch_pc <= END_ADDR) && !redirect &&
                        (occupancy <= 3'd1);
   end

   assign imem_addr   = fetch_pc;
   assign instr_valid = (count != 2'd0);
   assign instr       = instr_valid ? buf_data[0] : '0;
   assign instr_pc    = instr_valid ? buf_pc[0]   : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         fetch_pc     <= RESET_ADDR;
         inflight     <= 1'b0;
         inflight_pc  <= '0;
         count        <= 2'd0;
         buf_data[0]  <= '0;
         buf_data[1]  <= '0;
         buf_pc[0]    <= '0;
         buf_pc[1]    <= '0;
         accepted_cnt <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         if (pop && (accepted_cnt != '1))
            accepted_cnt <= accepted_cnt + CNT_WIDTH'(1);
         case (state)
            S_IDLE, S_DONE: begin
               inflight <= 1'b0;
               if (start) begin
                  state        <= S_RUN;
                  fetch_pc     <= RESET_ADDR;
                  accepted_cnt <= '0;
                  busy         <= 1'b1;
                  done         <= 1'b0;
               end
            end
            default: begin
               if (redirect) begin
                  count    <= 2'd0;
                  inflight <= 1'b0;
                  fetch_pc <= redirect_pc;
                  state    <= S_RUN;
               end else begin
                  if (pop) begin
                     buf_data[0] <= buf_data[1];
                     buf_pc[0]   <= buf_pc[1];
                  end
                  // The returning word lands behind whatever survives this cycle's pop.
                  if (inflight) begin
                     buf_data[count_after_pop[0]] <= imem_data;
                     buf_pc[count_after_pop[0]]   <= inflight_pc;
                  end
                  count    <= count_next;
                  inflight <= issue;
                  if (issue) begin
                     inflight_pc <= fetch_pc;
                     fetch_pc    <= fetch_pc + ADDR_WIDTH'(1);
                  end
                  if (state == S_RUN) begin
                     if ((issue && (fetch_pc == END_ADDR)) || (fetch_pc > END_ADDR))
                        state <= S_DRAIN;
                  end else if (count_next == 2'd0) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && busy && !redirect)
         assert (!(inflight && (count_after_pop == 2'd2)));
   end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - scoreboard bench for imem_fetch_ctrl
// Expected pc stream is a queue of program addresses; a negedge monitor checks the head.
module tb_imem_fetch_ctrl;
   localparam int DW  = 32;
   localparam int AW  = 10;
   localparam int RPC = 0;
   localparam int EPC = 17;
   localparam int CW  = 16;
   localparam logic [DW-1:0] BASE = 32'hA000_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_data = '0;
   logic [DW-1:0] instr;
   logic [AW-1:0] instr_pc;
   logic          instr_valid;
   logic          instr_ready = 1'b0;
   logic          redirect = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic          busy;
   logic          done;
   logic [CW-1:0] accepted_cnt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int expq[$];
   int pushed = 0;
   int flushed = 0;
   int xfer_n = 0;
   int xfer_first = 0;
   int xfer_last = 0;

   imem_fetch_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(RPC), .END_PC(EPC), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .imem_addr(imem_addr), .imem_data(imem_data),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy), .done(done),
      .accepted_cnt(accepted_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // Memory model: word k holds BASE + k, one-cycle registered read.
   always @(posedge clk) imem_data <= BASE + DW'(imem_addr);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Monitor: whenever the DUT presents an instruction it must be the scoreboard head.
   always @(negedge clk) begin
      if (!rst && instr_valid) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid actual_pc=%0d required=none", instr_pc);
         end else begin
            chk("head_pc", instr_pc, expq[0]);
            chk("head_data", instr, BASE + DW'(expq[0]));
            if (instr_ready) begin
               void'(expq.pop_front());
               if (xfer_n == 0) xfer_first = cyc;
               xfer_last = cyc;
               xfer_n++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_range(input int first);
      for (int p = first; p <= EPC; p++) begin
         expq.push_back(p);
         pushed++;
      end
   endtask

   task automatic do_start(output int sc);
      pushed = 0;
      flushed = 0;
      xfer_n = 0;
      push_range(RPC);
      start = 1'b1;
      tick();
      sc = cyc;
      start = 1'b0;
   endtask

   task automatic do_redirect(input int target, output int r);
      redirect = 1'b1;
      redirect_pc = AW'(target);
      tick();
      r = cyc;
      redirect = 1'b0;
      flushed += expq.size();
      expq.delete();
      push_range(target);
   endtask

   task automatic wait_pc(input string tag, input int pc);
      int n = 0;
      while (!(instr_valid && instr_pc == AW'(pc)) && n < 60) begin
         tick();
         n++;
      end
      chk({tag, "_reach_pc"}, instr_pc, pc);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 400) begin
         tick();
         n++;
      end
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_queue_left"}, expq.size(), 0);
      chk({tag, "_accepted"}, accepted_cnt, pushed - flushed);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_valid"}, instr_valid, 0);
      chk({tag, "_instr"}, instr, 0);
      chk({tag, "_pc"}, instr_pc, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_cnt"}, accepted_cnt, 0);
      chk({tag, "_addr"}, imem_addr, RPC);
   endtask

   initial begin
      int sc;
      int r;
      logic [AW-1:0] a6;

      tick();
      tick();
      check_reset("reset");
      rst = 1'b0;

      // Full program, consumer always ready
      instr_ready = 1'b1;
      do_start(sc);
      chk("t1_busy_run", busy, 1);
      wait_done("t1");
      chk("t1_first_cycle", xfer_first, sc + 2);
      chk("t1_last_cycle", xfer_last, sc + 19);
      chk("t1_count", xfer_n, 18);

      // Consumer stalls in cycles 5..9
      do_start(sc);
      a6 = '0;
      for (int k = 1; k <= 12; k++) begin
         instr_ready = !(k >= 5 && k <= 9);
         if (k == 6) a6 = imem_addr;
         if (k == 7) begin
            chk("t2_stall_valid", instr_valid, 1);
            chk("t2_stall_instr", instr, BASE + 2);
            chk("t2_stall_pc", instr_pc, 2);
         end
         if (k == 9) chk("t2_addr_frozen", imem_addr, a6);
         tick();
      end
      chk("t2_addr_value", a6, 4);
      instr_ready = 1'b1;
      wait_done("t2");
      chk("t2_accepted", accepted_cnt, 18);

      // Redirect to 10 while pc 3 is accepted
      do_start(sc);
      wait_pc("t3", 3);
      do_redirect(10, r);
      chk("t3_flush_valid0", instr_valid, 0);
      tick();
      chk("t3_flush_valid1", instr_valid, 0);
      tick();
      chk("t3_target_valid", instr_valid, 1);
      chk("t3_target_pc", instr_pc, 10);
      chk("t3_target_instr", instr, BASE + 10);
      wait_done("t3");
      chk("t3_accepted", accepted_cnt, 12);

      // Redirect beyond the last address
      do_start(sc);
      wait_pc("t4", 5);
      do_redirect(20, r);
      chk("t4_valid0", instr_valid, 0);
      tick();
      chk("t4_valid1", instr_valid, 0);
      tick();
      chk("t4_done", done, 1);
      chk("t4_accepted", accepted_cnt, 6);

      // Reset in the middle of a run with a non-empty buffer
      do_start(sc);
      wait_pc("t5", 4);
      rst = 1'b1;
      tick();
      check_reset("t5_reset");
      rst = 1'b0;
      expq.delete();
      tick();
      chk("t5_idle_valid", instr_valid, 0);
      do_start(sc);
      wait_done("t5");

      // Start pulses during RUN are ignored; start in DONE restarts the count
      do_start(sc);
      chk("t6_cnt_restart", accepted_cnt, 0);
      for (int k = 0; k < 10; k++) begin
         start = (k % 3 == 0);
         tick();
      end
      start = 1'b0;
      wait_done("t6");
      chk("t6_accepted", accepted_cnt, 18);

      // Randomised ready, redirects and stray starts
      for (int run = 0; run < 6; run++) begin
         do_start(sc);
         for (int n = 0; n < 400 && !done; n++) begin
            instr_ready = ($urandom_range(0, 99) < 70);
            if (expq.size() != 0 && $urandom_range(0, 99) < 5) begin
               do_redirect(int'($urandom_range(0, 24)), r);
            end else begin
               start = (expq.size() != 0) && ($urandom_range(0, 99) < 5);
               tick();
               start = 1'b0;
            end
         end
         instr_ready = 1'b1;
         wait_done("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Fetch sequencer for the synchronous-read instruction memory (one-cycle read latency, registered output, ADDR_WIDTH word address). Owns the program counter, issues one read per cycle, and hides the read latency behind a 2-entry output buffer. Delivers instructions to the decode stage over a valid/ready handshake, supports redirect (branch/jump) with flush, and stops after a configured last address.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 10, word address width of instruction memory
RESET_PC, 0, first address fetched after start
END_PC, 17, last address fetched; fetching stops after issuing it
CNT_WIDTH, 16, width of the accepted-instruction counter

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  synchronous reset, active-high
start  in  1  begin fetching from RESET_PC; honoured only in IDLE or DONE
imem_addr  out  ADDR_WIDTH  address to instruction memory, registered (= fetch_pc)
imem_data  in  DATA_WIDTH  registered read data from instruction memory
instr  out  DATA_WIDTH  buffer-head instruction
instr_pc  out  ADDR_WIDTH  address of instr
instr_valid  out  1  buffer non-empty
instr_ready  in  1  consumer accepts; a transfer occurs when instr_valid && instr_ready
redirect  in  1  flush and continue fetching from redirect_pc
redirect_pc  in  ADDR_WIDTH  redirect target
busy  out  1  high in RUN and DRAIN
done  out  1  high in DONE
accepted_cnt  out  CNT_WIDTH  number of transfers since start; saturates at all-ones

Behaviour:
- Reset, and mid-operation reset: state IDLE, fetch_pc=imem_addr=RESET_PC, buffer empty, inflight=0, instr=0, instr_pc=0, instr_valid=0, busy=0, done=0, accepted_cnt=0. A memory read in progress at reset is discarded.
- States:
  - IDLE: on start, go to RUN, fetch_pc=RESET_PC, accepted_cnt=0.
  - RUN: issue reads.
    - After issuing END_PC, go to DRAIN.
    - If fetch_pc>END_PC with no issue (e.g. after a redirect), go to DRAIN.
  - DRAIN: no issue. Go to DONE when buffer empty and inflight=0, evaluated after this cycle's pop and writes.
  - DONE: outputs held. start behaves as in IDLE.
- Issue rule (cycle t):
  - Condition: state==RUN && fetch_pc<=END_PC && !redirect && (count + inflight - pop) <= 1, where pop = instr_valid && instr_ready.
  - Effect at the edge: memory samples imem_addr, inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1 (modulo 2^ADDR_WIDTH).
  - Without issue, inflight<=0.
- Return: when inflight=1, imem_data is written to the buffer tail with inflight_pc at the next edge.
- Latency:
  - start sampled at edge E0 → first issue in cycle 1 → data in cycle 2 → instr_valid high in cycle 3.
  - Sustained throughput is 1 instruction/cycle with instr_ready held high.
- Buffer:
  - 2-entry FIFO, ordered by pc.
  - Push and pop in the same cycle are both applied.
  - The issue rule guarantees no overflow; overflow is an assertion failure.
  - instr/instr_pc hold stable while instr_valid && !instr_ready.
  - instr and instr_pc read 0 when empty.
- Redirect (honoured in RUN/DRAIN; ignored in IDLE/DONE):
  - Has priority over issue, push and state transitions.
  - A pop in the same cycle still counts as accepted (the counter increments).
  - At the edge: buffer flushed, inflight data discarded, fetch_pc<=redirect_pc, state<=RUN.
  - First redirected instruction: instr_valid high 3 cycles after the redirect edge.
- Start while RUN/DRAIN: ignored.
- accepted_cnt: +1 per transfer, saturating.
- END_PC=2^ADDR_WIDTH-1: DRAIN is entered after issuing the top address; fetch_pc wraps to 0 but is never issued.

Test Plan:
- Memory word k = 32'hA000_0000+k, END_PC=17, instr_ready=1, pulse start → instr 32'hA000_0000..32'hA000_0011 on 18 consecutive cycles starting 3 cycles after the start edge; instr_pc 0..17; then done=1, busy=0, accepted_cnt=18.
- Same program, instr_ready low for cycles 5..9 → no loss or duplication; instr holds (e.g. 32'hA000_0002, pc 2) during the stall; imem_addr stops advancing; ordering preserved; accepted_cnt=18.
- Redirect to pc 10 when instr_pc=3 is accepted → pc 3 counted, buffered/in-flight pcs 4,5 never appear; next instr_pc=10 (32'hA000_000A) 3 cycles later; run ends at 17; accepted_cnt=4+8=12.
- Redirect to pc 20 (> END_PC) → no further instr_valid; done=1 within 2 cycles.
- rst asserted mid-run with a non-empty buffer → next cycle all outputs are reset values; start afterwards refetches from pc 0.
- start in DONE → rerun from RESET_PC, accepted_cnt restarts from 0; start pulses during RUN have no effect.
